general_register_file: RTL and testbench
========================================

# general_register_file

Eight-entry 32-bit x86 general register file (EAX..EDI) with built-in operand-width decode, replacing the standalone register-select decoder in the decode stage. Each port takes the 3-bit `reg` field plus the instruction's `w`-field information and resolves 8-bit (AL..BH), 16-bit (AX..DI) or 32-bit (EAX..EDI) views itself. The block provides a parametrised number of registered read ports and one merging write port. It sits between the decode stage and the execute unit.

## Interface
- `NUM_READ_PORTS`, 2: number of independent read ports, 1..4.
- `RESET_VALUE`, 32'h0000_0000: value loaded into every register on reset.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clock` rising edge.
- `rd_en`  in  NUM_READ_PORTS  per-port read request.
- `rd_reg`  in  3*NUM_READ_PORTS  per-port `reg` field.
- `rd_w_in_instruction`  in  NUM_READ_PORTS  per-port flag: the opcode contains a `w` bit.
- `rd_w`  in  NUM_READ_PORTS  per-port `w` bit.
- `rd_size32`  in  NUM_READ_PORTS  per-port effective operand size: 1 = 32-bit, 0 = 16-bit.
- `rd_valid`  out  NUM_READ_PORTS  per-port: read data is valid.
- `rd_data`  out  32*NUM_READ_PORTS  per-port selected view, zero-extended to 32 bits.
- `wr_en`, `wr_reg[2:0]`, `wr_w_in_instruction`, `wr_w`, `wr_size32`  in  write request and its width selection, same encoding as the read ports.
- `wr_data`  in  32  write data; the low bits carry the value for the selected view.
- `dbg_reg`  out  32*8  flat register contents; `dbg_reg[32*i +: 32]` holds register i.

## Operation
- Width decode, identical for read and write:
  - `w_in_instruction=0` → full operand size.
  - `w_in_instruction=1, w=1` → full operand size.
  - `w_in_instruction=1, w=0` → byte access.
- Full operand size is 32-bit when `size32=1` and 16-bit otherwise.
- Byte access:
  - `reg` 0..3 → bits [7:0] of register `reg` (AL, CL, DL, BL).
  - `reg` 4..7 → bits [15:8] of register `reg-4` (AH, CH, DH, BH).
- 16-bit access → bits [15:0] of register `reg`.
- 32-bit access → bits [31:0] of register `reg`.
- Write merge: only the selected byte lanes change; all other bits of the target register keep their value.
  - AH write: lane 1 of register 0 takes `wr_data[7:0]`.
  - 16-bit write: lanes 0-1 take `wr_data[15:0]`.
- Read: the selected view is right-aligned in `rd_data` and the upper bits are zero.
  - AH read returns `{24'h0, reg0[15:8]}`.
- Any combination of ports may read the same register in the same cycle.

## Timing
- Reset, for one or more cycles:
  - all 8 registers ← RESET_VALUE.
  - `rd_valid` ← 0; `rd_data` ← 0.
  - `dbg_reg` shows RESET_VALUE ×8 after the edge.
- Reset overrides a coincident `wr_en` or `rd_en`. Requests presented in the reset cycle are dropped and are not replayed.
- Write: the request is sampled at edge N. The register is updated at edge N; `dbg_reg` reflects it after edge N.
- Read latency is 1 cycle. `rd_en` is sampled at edge N; `rd_valid`/`rd_data` are driven after edge N and held until the next edge.
- `rd_en=0` → `rd_valid` is 0 next cycle and `rd_data` holds its previous value.
- Same-cycle read/write to the same physical register is governed by Configuration.
- Reads of a different register than the one being written are unaffected.
- Back-to-back writes to the same register on consecutive cycles: each merges into the result of the previous write.
- No stall or backpressure: every request is accepted every cycle.

## Configuration
- `GENERAL_REGISTER_BYPASS_EN` defined:
  - A read and a write to the same physical register in the same cycle returns the post-merge value.
  - Example: AH written with 8'h5A while EAX is read → read returns the new merged EAX.
- Macro undefined:
  - The read returns the pre-write value.
  - The write lands in the same cycle and is visible to reads from the next request onward.

## Test plan
- Reset then read EAX..EDI (`w_in_instruction=0`, `size32=1`) → `rd_data`=0 for each, `rd_valid`=1 one cycle after `rd_en`.
- Write EAX=32'h1234_5678; read AL, AH, AX, EAX on four consecutive requests → 32'h78, 32'h56, 32'h5678, 32'h1234_5678.
- EBX=32'hFFFF_FFFF, then write BH (`reg`=7, w=0, `wr_data`=8'h00) → EBX=32'hFFFF_00FF; then write BX (16-bit, 16'hABCD) → EBX=32'hFFFF_ABCD.
- NUM_READ_PORTS=2: port 0 reads CH while port 1 reads ECX (ECX=32'h0000_BE00), same cycle → 32'hBE, 32'h0000_BE00.
- ECX=32'h0000_BE00; write ECX=32'hCAFE_F00D while reading ECX in the same cycle → with `GENERAL_REGISTER_BYPASS_EN` 32'hCAFE_F00D; without it 32'h0000_BE00, then 32'hCAFE_F00D on the next read.
- EDX=32'h1111_1111; assert `reset` in the same cycle as `wr_en` (EDX←32'h9999_9999) → EDX=RESET_VALUE and `rd_valid`=0 the following cycle.

Source files
------------

// File: rtl/general_register_file.sv
// Eight-entry x86 general register file (EAX..EDI) with per-port operand-width decode.
// Optional feature: define GENERAL_REGISTER_BYPASS_EN to forward a same-cycle write to matching reads.
module general_register_file #(
  parameter int          NUM_READ_PORTS = 2,
  parameter logic [31:0] RESET_VALUE    = 32'h0000_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_READ_PORTS-1:0]     rd_en,
  input  logic [3*NUM_READ_PORTS-1:0]   rd_reg,
  input  logic [NUM_READ_PORTS-1:0]     rd_w_in_instruction,
  input  logic [NUM_READ_PORTS-1:0]     rd_w,
  input  logic [NUM_READ_PORTS-1:0]     rd_size32,
  output logic [NUM_READ_PORTS-1:0]     rd_valid,
  output logic [32*NUM_READ_PORTS-1:0]  rd_data,
  input  logic                          wr_en,
  input  logic [2:0]                    wr_reg,
  input  logic                          wr_w_in_instruction,
  input  logic                          wr_w,
  input  logic                          wr_size32,
  input  logic [31:0]                   wr_data,
  output logic [32*8-1:0]               dbg_reg
);

  typedef enum logic [1:0] {
    VIEW_LO8 = 2'd0,
    VIEW_HI8 = 2'd1,
    VIEW_16  = 2'd2,
    VIEW_32  = 2'd3
  } view_e;

  typedef struct packed {
    logic [2:0] idx;
    view_e      view;
  } access_t;

  // Byte accesses with reg 4..7 address the high byte of registers 0..3.
  function automatic access_t decode_access(input logic [2:0] reg_field,
                                            input logic       w_in_instr,
                                            input logic       w_bit,
                                            input logic       size32);
    access_t acc;
    acc.idx  = reg_field;
    acc.view = size32 ? VIEW_32 : VIEW_16;
    if (w_in_instr && !w_bit) begin
      acc.idx  = {1'b0, reg_field[1:0]};
      acc.view = reg_field[2] ? VIEW_HI8 : VIEW_LO8;
    end
    return acc;
  endfunction

  function automatic logic [31:0] view_bit_mask(input view_e view);
    logic [31:0] mask;
    case (view)
      VIEW_LO8: mask = 32'h0000_00FF;
      VIEW_HI8: mask = 32'h0000_FF00;
      VIEW_16:  mask = 32'h0000_FFFF;
      default:  mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] align_write(input view_e view, input logic [31:0] data);
    logic [31:0] aligned;
    case (view)
      VIEW_LO8: aligned = {24'h0, data[7:0]};
      VIEW_HI8: aligned = {16'h0, data[7:0], 8'h0};
      VIEW_16:  aligned = {16'h0, data[15:0]};
      default:  aligned = data;
    endcase
    return aligned;
  endfunction

  function automatic logic [31:0] extract_view(input view_e view, input logic [31:0] word);
    logic [31:0] result;
    case (view)
      VIEW_LO8: result = {24'h0, word[7:0]};
      VIEW_HI8: result = {24'h0, word[15:8]};
      VIEW_16:  result = {16'h0, word[15:0]};
      default:  result = word;
    endcase
    return result;
  endfunction

  logic [31:0] r_regs [8];
  access_t     w_wr_acc;
  logic [31:0] w_wr_mask;
  logic [31:0] w_wr_merged;

  assign w_wr_acc = decode_access(wr_reg, wr_w_in_instruction, wr_w, wr_size32);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_wr_mask   = view_bit_mask(w_wr_acc.view);
    w_wr_merged = r_regs[w_wr_acc.idx];
    w_wr_merged = (w_wr_merged & ~w_wr_mask)
                | (align_write(w_wr_acc.view, wr_data) & w_wr_mask);
  end

  // NOTE: the register array is reset explicitly because software observes RESET_VALUE after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= RESET_VALUE;
    end else if (wr_en) begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
      r_regs[w_wr_acc.idx] <= w_wr_merged;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : gen_dbg
    assign dbg_reg[32*g +: 32] = r_regs[g];
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gen_rd_port
    access_t     w_rd_acc;
    logic [31:0] w_rd_src;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;

    assign w_rd_acc = decode_access(rd_reg[3*p +: 3], rd_w_in_instruction[p],
                                    rd_w[p], rd_size32[p]);

    always_comb begin
      w_rd_src = r_regs[w_rd_acc.idx];
`ifdef GENERAL_REGISTER_BYPASS_EN
      // Forward the post-merge word when this cycle's write hits the same physical register.
      if (wr_en && (w_wr_acc.idx == w_rd_acc.idx)) w_rd_src = w_wr_merged;
`endif
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_rd_valid <= 1'b0;
        r_rd_data  <= 32'h0;
      end else begin
        r_rd_valid <= rd_en[p];
        if (rd_en[p]) r_rd_data <= extract_view(w_rd_acc.view, w_rd_src);
      end
    end

    assign rd_valid[p]          = r_rd_valid;
    assign rd_data[32*p +: 32]  = r_rd_data;
  end

endmodule

// File: tb/tb_general_register_file.sv
// Scoreboard bench for general_register_file: directed test-plan cases plus randomized traffic.
module tb_general_register_file;

  localparam int          NP = 2;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic               clock = 1'b0;
  logic               reset;
  logic [NP-1:0]      rd_en, rd_w_in_instruction, rd_w, rd_size32, rd_valid;
  logic [3*NP-1:0]    rd_reg;
  logic [32*NP-1:0]   rd_data;
  logic               wr_en, wr_w_in_instruction, wr_w, wr_size32;
  logic [2:0]         wr_reg;
  logic [31:0]        wr_data;
  logic [32*8-1:0]    dbg_reg;

  always #5 clock = ~clock;

  general_register_file #(.NUM_READ_PORTS(NP), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_reg(rd_reg), .rd_w_in_instruction(rd_w_in_instruction),
    .rd_w(rd_w), .rd_size32(rd_size32), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_w_in_instruction(wr_w_in_instruction),
    .wr_w(wr_w), .wr_size32(wr_size32), .wr_data(wr_data), .dbg_reg(dbg_reg)
  );

  typedef struct packed {
    logic [31:0]           due;
    logic [NP-1:0]         v;
    logic [NP-1:0][31:0]   d;
    logic [7:0][31:0]      r;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mregs  [8];
  logic [31:0] last_d [NP];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops each expectation in the cycle it falls due and compares all outputs.
  always @(negedge clock) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check("sb_due_cycle", e.due, cyc);
      for (int p = 0; p < NP; p++) begin
        check($sformatf("rd_valid[%0d] cyc=%0d", p, cyc), 32'(rd_valid[p]), 32'(e.v[p]));
        check($sformatf("rd_data[%0d] cyc=%0d", p, cyc), rd_data[32*p +: 32], e.d[p]);
      end
      for (int i = 0; i < 8; i++)
        check($sformatf("dbg_reg[%0d] cyc=%0d", i, cyc), dbg_reg[32*i +: 32], e.r[i]);
    end
  end

  // Reference model: register views straight from the x86 naming rules.
  function automatic logic [31:0] model_read(input logic [2:0] r, input logic wi,
                                             input logic w, input logic s32);
    if (wi && !w) begin
      if (r < 3'd4) return {24'h0, mregs[r][7:0]};
      else          return {24'h0, mregs[3'(r - 3'd4)][15:8]};
    end
    if (s32) return mregs[r];
    return {16'h0, mregs[r][15:0]};
  endfunction

  task automatic model_write();
    if (wr_w_in_instruction && !wr_w) begin
      if (wr_reg < 3'd4) mregs[wr_reg][7:0]            = wr_data[7:0];
      else               mregs[3'(wr_reg - 3'd4)][15:8] = wr_data[7:0];
    end else if (wr_size32) mregs[wr_reg]        = wr_data;
    else                    mregs[wr_reg][15:0]  = wr_data[15:0];
  endtask

  // Issue the currently driven request for one clock and queue what it must produce.
  task automatic step();
    exp_t e;
    e     = '0;
    e.due = cyc + 1;
    if (reset) begin
      for (int i = 0; i < 8; i++) mregs[i] = RV;
      for (int p = 0; p < NP; p++) last_d[p] = 32'h0;
    end else begin
`ifdef GENERAL_REGISTER_BYPASS_EN
      if (wr_en) model_write();
`endif
      for (int p = 0; p < NP; p++) begin
        e.v[p] = rd_en[p];
        if (rd_en[p])
          last_d[p] = model_read(rd_reg[3*p +: 3], rd_w_in_instruction[p], rd_w[p], rd_size32[p]);
      end
`ifndef GENERAL_REGISTER_BYPASS_EN
      if (wr_en) model_write();
`endif
    end
    for (int p = 0; p < NP; p++) e.d[p] = last_d[p];
    for (int i = 0; i < 8; i++)  e.r[i] = mregs[i];
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    reset = 1'b0; rd_en = '0; rd_reg = '0; rd_w_in_instruction = '0; rd_w = '0; rd_size32 = '0;
    wr_en = 1'b0; wr_reg = '0; wr_w_in_instruction = 1'b0; wr_w = 1'b0; wr_size32 = 1'b0;
    wr_data = '0;
  endtask

  task automatic set_rd(input int p, input logic [2:0] r, input logic wi,
                        input logic w, input logic s32);
    rd_en[p] = 1'b1; rd_reg[3*p +: 3] = r; rd_w_in_instruction[p] = wi;
    rd_w[p] = w; rd_size32[p] = s32;
  endtask

  task automatic set_wr(input logic [2:0] r, input logic wi, input logic w,
                        input logic s32, input logic [31:0] data);
    wr_en = 1'b1; wr_reg = r; wr_w_in_instruction = wi; wr_w = w;
    wr_size32 = s32; wr_data = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_req();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1; step();

    // Reset values on every register, two ports reading opposite ends.
    for (int i = 0; i < 8; i++) begin
      clear_req();
      set_rd(0, 3'(i), 1'b0, 1'b0, 1'b1);
      set_rd(1, 3'(7 - i), 1'b0, 1'b0, 1'b1);
      step();
    end

    // EAX views: AL, AH, AX, EAX.
    clear_req(); set_wr(3'd0, 1'b0, 1'b0, 1'b1, 32'h1234_5678); step();
    clear_req(); set_rd(0, 3'd0, 1'b1, 1'b0, 1'b0); step();
    clear_req(); set_rd(0, 3'd4, 1'b1, 1'b0, 1'b0); step();
    clear_req(); set_rd(0, 3'd0, 1'b0, 1'b0, 1'b0); step();
    clear_req(); set_rd(0, 3'd0, 1'b1, 1'b1, 1'b1); step();

    // EBX merges: BH then BX on consecutive cycles.
    clear_req(); set_wr(3'd3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF); step();
    clear_req(); set_wr(3'd7, 1'b1, 1'b0, 1'b0, 32'hFFFF_FF00); step();
    clear_req(); set_wr(3'd3, 1'b0, 1'b0, 1'b0, 32'h5555_ABCD); step();
    clear_req(); set_rd(1, 3'd3, 1'b0, 1'b0, 1'b1); step();

    // CH and ECX on both ports in one cycle.
    clear_req(); set_wr(3'd1, 1'b0, 1'b0, 1'b1, 32'h0000_BE00); step();
    clear_req(); set_rd(0, 3'd5, 1'b1, 1'b0, 1'b1); set_rd(1, 3'd1, 1'b0, 1'b0, 1'b1); step();

    // Same-cycle write and read of ECX, then the follow-up read.
    clear_req(); set_wr(3'd1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D); set_rd(0, 3'd1, 1'b0, 1'b0, 1'b1); step();
    clear_req(); set_rd(0, 3'd1, 1'b0, 1'b0, 1'b1); step();

    // AH write while EAX is read on the other port.
    clear_req(); set_wr(3'd4, 1'b1, 1'b0, 1'b1, 32'h0000_005A); set_rd(1, 3'd0, 1'b0, 1'b0, 1'b1); step();

    // Reset wins over a coincident write and reads.
    clear_req(); set_wr(3'd2, 1'b0, 1'b0, 1'b1, 32'h1111_1111); step();
    clear_req(); reset = 1'b1; set_wr(3'd2, 1'b0, 1'b0, 1'b1, 32'h9999_9999);
    set_rd(0, 3'd2, 1'b0, 1'b0, 1'b1); set_rd(1, 3'd2, 1'b0, 1'b0, 1'b1); step();
    clear_req(); step();
    clear_req(); set_rd(0, 3'd2, 1'b0, 1'b0, 1'b1); step();

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      clear_req();
      reset = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) != 0)
          set_rd(p, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0)
        set_wr(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      step();
    end

    clear_req();
    repeat (3) step();
    repeat (2) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
